// File: rtl/btcminer_pkg.sv
// Shared types and constants for the check-bits status path.
// The FSM encoding lives here so every module decodes the same values.
package btcminer_pkg;

  localparam logic [15:0] CHECK_START = 16'hAB60;
  localparam logic [15:0] CHECK_PASS  = 16'hAB61;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_LOCKED = 2'd2
  } check_state_t;

  typedef struct packed {
    logic        is_final;
    logic [15:0] data;
  } check_entry_t;

  localparam int ENTRY_W = $bits(check_entry_t);

endpackage

// File: rtl/checkbits_fifo.sv
// Synchronous FIFO for status codes; a separate count register decides full/empty
// so the pointers can simply wrap at DEPTH.
module checkbits_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty/full gating keeps stale entries invisible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/checkbits_driver.sv
// Drives status codes onto mprj_io[31:16], holding each for HOLD_CYCLES cycles.
//   state     | meaning
//   ST_IDLE   | nothing displayed recently; pop as soon as a code is queued
//   ST_HOLD   | current code held until the counter reaches zero
//   ST_LOCKED | terminal code shown; frozen until reset
module checkbits_driver
  import btcminer_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter int          HOLD_CYCLES = 64,
  parameter logic [15:0] IDLE_CODE   = 16'h0000
) (
  input  logic        wb_clk_i,
  input  logic        resetb,
  input  logic        code_valid,
  input  logic [15:0] code_data,
  input  logic        code_final,
  output logic        code_ready,
  output logic [15:0] check_out,
  output logic [15:0] check_oeb,
  output logic        busy,
  output logic        overflow
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  check_state_t      state;
  check_state_t      state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              final_accepted;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  check_entry_t      push_entry;
  check_entry_t      head;

  assign push_entry = '{is_final: code_final, data: code_data};

  checkbits_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (wb_clk_i),
    .resetb    (resetb),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = head.is_final ? ST_LOCKED : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = head.is_final ? ST_LOCKED : ST_HOLD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_LOCKED: state_nxt = ST_LOCKED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Ready depends only on registered state: a pop on the same edge does not free a slot.
  always_comb begin
    code_ready = !fifo_full && !final_accepted;
    push       = code_valid && code_ready;
    busy       = !fifo_empty || (hold_cnt != '0);
    check_oeb  = '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!resetb) begin
      check_out      <= IDLE_CODE;
      hold_cnt       <= '0;
      final_accepted <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (pop) begin
        check_out <= head.data;
        hold_cnt  <= HOLD_LOAD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (push && code_final) final_accepted <= 1'b1;
      if (code_valid && !code_ready && state != ST_LOCKED) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_checkbits_driver.sv
// Bench for checkbits_driver: vector table, directed corner cases and a
// queue-based reference model under random traffic.
module tb_checkbits_driver;
  import btcminer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstb, a_valid, a_final, a_ready, a_busy, a_ovf;
  logic [15:0] a_data, a_out, a_oeb;
  logic        b_rstb, b_valid, b_final, b_ready, b_busy, b_ovf;
  logic [15:0] b_data, b_out, b_oeb;

  checkbits_driver #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD_A), .IDLE_CODE(16'h0000)) dut_a (
    .wb_clk_i(clk), .resetb(a_rstb), .code_valid(a_valid), .code_data(a_data),
    .code_final(a_final), .code_ready(a_ready), .check_out(a_out), .check_oeb(a_oeb),
    .busy(a_busy), .overflow(a_ovf));

  checkbits_driver #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD_B), .IDLE_CODE(16'h0000)) dut_b (
    .wb_clk_i(clk), .resetb(b_rstb), .code_valid(b_valid), .code_data(b_data),
    .code_final(b_final), .code_ready(b_ready), .check_out(b_out), .check_oeb(b_oeb),
    .busy(b_busy), .overflow(b_ovf));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pending codes in a queue, plus how many more edges the
  // displayed code must stay up.
  logic [16:0] m_q[$];
  logic [15:0] m_shown;
  int          m_left;
  bit          m_locked, m_fin, m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_shown = 16'h0000; m_left = 0; m_locked = 0; m_fin = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit rstb, input bit v, input bit f, input logic [15:0] d);
    bit          ready;
    logic [16:0] e;
    if (!rstb) begin
      model_reset();
      return;
    end
    ready = (m_q.size() < DEPTH) && !m_fin;
    if (v && !ready && !m_locked) m_ovf = 1;
    if (!m_locked && m_left == 0 && m_q.size() > 0) begin
      e = m_q.pop_front();
      m_shown  = e[15:0];
      m_left   = HOLD_A - 1;
      m_locked = e[16];
    end else if (m_left > 0) begin
      m_left--;
    end
    if (v && ready) begin
      m_q.push_back({f, d});
      if (f) m_fin = 1;
    end
  endtask

  task automatic cycle_a(input string tag);
    @(posedge clk); #1;
    model_step(a_rstb, a_valid, a_final, a_data);
    check({tag, " out"},   a_out,   m_shown);
    check({tag, " ready"}, a_ready, (m_q.size() < DEPTH) && !m_fin);
    check({tag, " busy"},  a_busy,  (m_q.size() > 0) || (m_left > 0));
    check({tag, " ovf"},   a_ovf,   m_ovf);
    check({tag, " oeb"},   a_oeb,   16'h0000);
  endtask

  typedef struct {
    bit          rstb, valid, fin;
    logic [15:0] data, exp_out;
    bit          exp_ready, exp_busy, exp_ovf;
  } vec_t;
  vec_t tbl[12];

  initial begin
    bit          acc, full_pop, saw_full_pop;
    logic [15:0] exp_b;

    a_rstb = 0; a_valid = 0; a_final = 0; a_data = 0;
    b_rstb = 0; b_valid = 0; b_final = 0; b_data = 0;
    model_reset();

    // Reset, then START followed by final PASS with a short hold.
    tbl[0]  = '{0, 0, 0, 16'h0000,    16'h0000,    1, 0, 0};
    tbl[1]  = '{0, 0, 0, 16'h0000,    16'h0000,    1, 0, 0};
    tbl[2]  = '{1, 1, 0, CHECK_START, 16'h0000,    1, 1, 0};
    tbl[3]  = '{1, 1, 1, CHECK_PASS,  CHECK_START, 0, 1, 0};
    tbl[4]  = '{1, 0, 0, 16'h0000,    CHECK_START, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 16'h0000,    CHECK_START, 0, 1, 0};
    tbl[6]  = '{1, 0, 0, 16'h0000,    CHECK_START, 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 16'h0000,    CHECK_PASS,  0, 1, 0};
    tbl[8]  = '{1, 1, 0, 16'h5555,    CHECK_PASS,  0, 1, 0};
    tbl[9]  = '{1, 0, 0, 16'h0000,    CHECK_PASS,  0, 1, 0};
    tbl[10] = '{1, 1, 0, 16'h7777,    CHECK_PASS,  0, 0, 0};
    tbl[11] = '{1, 0, 0, 16'h0000,    CHECK_PASS,  0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      a_rstb = tbl[i].rstb; a_valid = tbl[i].valid;
      a_final = tbl[i].fin; a_data = tbl[i].data;
      @(posedge clk); #1;
      model_step(a_rstb, a_valid, a_final, a_data);
      check($sformatf("tbl%0d out", i),   a_out,   tbl[i].exp_out);
      check($sformatf("tbl%0d ready", i), a_ready, tbl[i].exp_ready);
      check($sformatf("tbl%0d busy", i),  a_busy,  tbl[i].exp_busy);
      check($sformatf("tbl%0d ovf", i),   a_ovf,   tbl[i].exp_ovf);
      check($sformatf("tbl%0d oeb", i),   a_oeb,   16'h0000);
    end
    a_valid = 0;

    // Producer keeps offering; a full FIFO must refuse even while popping.
    a_rstb = 0; cycle_a("fullrst");
    a_rstb = 1; a_final = 0; a_data = 16'h0100; a_valid = 1;
    saw_full_pop = 0;
    for (int i = 0; i < 30; i++) begin
      acc      = a_valid && a_ready;
      full_pop = (m_q.size() == DEPTH) && m_left == 0 && !m_locked;
      cycle_a("full");
      if (full_pop) begin
        saw_full_pop = 1;
        check("full pop accept next", a_ready, 1'b1);
      end
      if (acc) a_data = a_data + 16'h1;
    end
    check("full pop seen", saw_full_pop, 1'b1);
    a_valid = 0;

    // Reset in the middle of HOLD with three codes queued.
    a_rstb = 0; cycle_a("midrst0");
    a_rstb = 1; a_valid = 1; a_data = 16'h1234; cycle_a("mid push");
    a_data = 16'h0011; cycle_a("mid q1");
    a_data = 16'h0022; cycle_a("mid q2");
    a_data = 16'h0033; cycle_a("mid q3");
    a_valid = 0;
    check("mid shown", a_out, 16'h1234);
    a_rstb = 0; cycle_a("mid rst");
    check("mid rst out", a_out, 16'h0000);
    check("mid rst busy", a_busy, 1'b0);
    a_rstb = 1;
    for (int i = 0; i < 20; i++) begin
      cycle_a("mid after");
      check("mid never shown", a_out, 16'h0000);
    end

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      a_rstb  = ($urandom_range(0, 119) != 0);
      a_valid = ($urandom_range(0, 9) < 6);
      a_final = ($urandom_range(0, 79) == 0);
      a_data  = 16'($urandom);
      cycle_a("rand");
    end
    a_valid = 0; a_final = 0;

    // Long hold: six back-to-back offers, sixth overflows, queued codes every 64 cycles.
    check("b reset out", b_out, 16'h0000);
    check("b reset oeb", b_oeb, 16'h0000);
    check("b reset ready", b_ready, 1'b1);
    check("b reset busy", b_busy, 1'b0);
    check("b reset ovf", b_ovf, 1'b0);
    b_rstb = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      b_valid = 1; b_data = 16'hC000 + 16'(i);
      @(posedge clk); #1;
      if (i == 0) check("b first not yet", b_out, 16'h0000);
      if (i == 1) check("b first shown", b_out, 16'hC000);
      if (i == 4) begin
        check("b ready after 5th", b_ready, 1'b0);
        check("b ovf after 5th", b_ovf, 1'b0);
      end
      if (i == 5) check("b ovf after 6th", b_ovf, 1'b1);
    end
    b_valid = 0;
    for (int e = 6; e <= 330; e++) begin
      @(posedge clk); #1;
      if      (e < 65)  exp_b = 16'hC000;
      else if (e < 129) exp_b = 16'hC001;
      else if (e < 193) exp_b = 16'hC002;
      else if (e < 257) exp_b = 16'hC003;
      else              exp_b = 16'hC004;
      check($sformatf("b out e%0d", e), b_out, exp_b);
      check($sformatf("b busy e%0d", e), b_busy, e < 320);
      if (e == 65) check("b ready after pop", b_ready, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/checkbits_driver.md
CHECKBITS_DRIVER -- requirements
Module: checkbits_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4: status FIFO entries, power of two and at least 2.
REQ-002 SHALL have parameter HOLD_CYCLES, default 64: minimum number of cycles each code stays on the pins, at least 1.
REQ-003 SHALL have parameter IDLE_CODE, default 16'h0000: value driven on the pins after reset.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the only clock; every flop samples on its rising edge.
REQ-005 SHALL have port resetb, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port code_valid, input, 1 bit: the producer offers a status code.
REQ-007 SHALL have port code_data, input, 16 bits: the status code, for example 16'hAB60 or 16'hAB61.
REQ-008 SHALL have port code_final, input, 1 bit: the offered code is terminal.
REQ-009 SHALL have port code_ready, output, 1 bit: the block accepts the offered code.
REQ-010 SHALL have port check_out, output, 16 bits: value for mprj_io[31:16].
REQ-011 SHALL have port check_oeb, output, 16 bits: active-low output enable for mprj_io[31:16].
REQ-012 SHALL have port busy, output, 1 bit: FIFO not empty or hold counter not zero.
REQ-013 SHALL have port overflow, output, 1 bit: sticky; set when code_valid is high while code_ready is low, except in LOCKED.

Function
REQ-014 SHALL transfer a code on any edge where code_valid and code_ready are both high; code_data and code_final are written into the FIFO together.
REQ-015 SHALL drive code_ready = !full && !final_accepted, as a registered-state function with no same-cycle bypass: a full FIFO refuses the code even when a pop happens on the same edge.
REQ-016 SHALL set final_accepted on a transfer with code_final=1; from then on code_ready stays 0 until reset.
REQ-017 SHALL implement states IDLE, HOLD and LOCKED.
REQ-018 SHALL hold check_out and the hold counter in IDLE; when the FIFO is not empty it pops the head, registers it onto check_out and goes to HOLD with counter=HOLD_CYCLES-1.
REQ-019 SHALL decrement the counter by 1 per cycle in HOLD.
REQ-020 SHALL leave HOLD when the counter is 0: with the FIFO not empty it pops the next head on that same edge, reloads the counter and stays in HOLD; with the FIFO empty it goes to IDLE and keeps the last code on check_out.
REQ-021 SHALL enter LOCKED instead of HOLD when the popped entry has final=1; LOCKED holds check_out forever, does no further pops and exits only on reset.
REQ-022 SHALL show a pushed code on check_out after the second rising edge: push at edge N, pop at edge N+1, when the FIFO is empty and the block is in IDLE.
REQ-023 SHALL keep every displayed code, including the last one before LOCKED, for at least HOLD_CYCLES cycles; with HOLD_CYCLES=1 codes change on consecutive edges.
REQ-024 SHALL handle push and pop on the same edge with the FIFO neither full nor empty with both taking effect and the count unchanged.
REQ-025 SHALL use wrapping pointers of width log2(DEPTH), with a separate count register of width log2(DEPTH)+1 that decides full and empty.
REQ-026 SHALL change check_out only on a pop and never show a partially updated value.

Reset
REQ-027 SHALL apply reset when resetb is low at a rising edge and give these values: state=IDLE, check_out=IDLE_CODE, check_oeb=16'h0000 (pins driven), FIFO empty, counter=0, code_ready=1, busy=0, overflow=0, final_accepted=0.
REQ-028 SHALL, on reset in the middle of HOLD or LOCKED, discard all queued codes and show IDLE_CODE on the next edge.

Structure
REQ-029 SHALL place the state encoding and the constants CHECK_START=16'hAB60 and CHECK_PASS=16'hAB61 in the shared package btcminer_pkg.
REQ-030 SHALL implement the FIFO as the sub-module checkbits_fifo, a synchronous FIFO carrying 17 bits (data plus final) with push, pop, full and empty.

Verification
REQ-031 SHALL check reset: resetb low for 2 cycles -> check_out=16'h0000, check_oeb=16'h0000, code_ready=1, busy=0, overflow=0.
REQ-032 SHALL check sequencing: HOLD_CYCLES=4, push 16'hAB60 at edge 10, then 16'hAB61 with final=1 at edge 11 -> AB60 visible from edge 11, AB61 from edge 15, state LOCKED, code_ready=0 from edge 12.
REQ-033 SHALL check overflow: DEPTH=4, HOLD_CYCLES=64, push 6 codes back-to-back -> the first pops immediately and 4 are queued, code_ready falls after the 5th push, the 6th offer sets overflow=1, and the queued codes appear in order every 64 cycles.
REQ-034 SHALL check the full-FIFO edge: push offered on the same edge as a pop while full -> code_ready=0 on that edge, the code is not accepted, and the next cycle accepts it.
REQ-035 SHALL check reset in the middle of HOLD: 16'h1234 displayed with 3 codes queued, resetb low for one edge -> check_out=16'h0000, busy=0, and none of the queued codes ever appear.
REQ-036 SHALL check the LOCKED state: after the final code 16'hAB61, code_valid pulses -> check_out stays 16'hAB61 and overflow stays 0.
